// File: rtl/zube_bus_sequencer.sv
// Two-requester sequencer for the shared 8-bit register bus: arbitration, CS/strobe timing, read capture.
// Optional feature: define ZUBE_BUS_ROUND_ROBIN_EN for alternating tie-break; otherwise requester A has fixed priority.
module zube_bus_sequencer #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       reg1_cs_b,
  output logic       reg2_cs_b,
  output logic       write_strobe_b,
  output logic       read_strobe_b,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  input  logic [7:0] bus_din
);

  localparam int MAX_CYCLES =
    (SETUP_CYCLES > STROBE_CYCLES)
      ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
      : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_ACK
  } state_e;

  typedef enum logic {
    GRANT_A,
    GRANT_B
  } grant_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             sel_q, sel_d;
  grant_e           last_grant_q, last_grant_d;
  logic             pick_b;
  logic             in_xfer;

  logic       ack_a_q, ack_a_d;
  logic       ack_b_q, ack_b_d;
  logic [7:0] rdata_q, rdata_d;
  logic       cs1_q, cs1_d;
  logic       cs2_q, cs2_d;
  logic       ws_q, ws_d;
  logic       rs_q, rs_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;

  always_comb begin
`ifdef ZUBE_BUS_ROUND_ROBIN_EN
    pick_b = req_b && (!req_a || (last_grant_q == GRANT_A));
`else
    pick_b = req_b && !req_a;
`endif
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;
    dout_d       = dout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_a || req_b) begin
          we_d         = pick_b ? we_b : we_a;
          sel_d        = pick_b ? sel_b : sel_a;
          last_grant_d = pick_b ? GRANT_B : GRANT_A;
          if (we_d) dout_d = pick_b ? wdata_b : wdata_a;
          cnt_d        = SETUP_LD;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = STROBE_LD;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          // Last strobe cycle: the peripheral's read data is settled on bus_din here.
          if (!we_q) rdata_d = bus_din;
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Bus outputs are decoded from the next state so the pads change exactly on the state edge.
    in_xfer = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    cs1_d   = !(in_xfer && !sel_d);
    cs2_d   = !(in_xfer && sel_d);
    ws_d    = !((state_d == ST_STROBE) && we_d);
    rs_d    = !((state_d == ST_STROBE) && !we_d);
    oe_d    = in_xfer && we_d;
    ack_a_d = (state_d == ST_ACK) && (last_grant_d == GRANT_A);
    ack_b_d = (state_d == ST_ACK) && (last_grant_d == GRANT_B);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= 1'b0;
      last_grant_q <= GRANT_B;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      rdata_q      <= 8'h00;
      cs1_q        <= 1'b1;
      cs2_q        <= 1'b1;
      ws_q         <= 1'b1;
      rs_q         <= 1'b1;
      dout_q       <= 8'h00;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      rdata_q      <= rdata_d;
      cs1_q        <= cs1_d;
      cs2_q        <= cs2_d;
      ws_q         <= ws_d;
      rs_q         <= rs_d;
      dout_q       <= dout_d;
      oe_q         <= oe_d;
    end
  end

  assign ack_a          = ack_a_q;
  assign ack_b          = ack_b_q;
  assign rdata          = rdata_q;
  assign busy           = (state_q != ST_IDLE);
  assign reg1_cs_b      = cs1_q;
  assign reg2_cs_b      = cs2_q;
  assign write_strobe_b = ws_q;
  assign read_strobe_b  = rs_q;
  assign bus_dout       = dout_q;
  assign bus_oe         = oe_q;

endmodule

// File: tb/tb_zube_bus_sequencer.sv
// Bench for zube_bus_sequencer: default-timing instance (0) and SETUP=2/STROBE=3/HOLD=2 instance (1).
// Expected waveforms come from cycle arithmetic on the timing parameters and a small arbitration model.
module tb_zube_bus_sequencer;

`ifdef ZUBE_BUS_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset   [2];
  logic       req_a   [2];
  logic       req_b   [2];
  logic       we_a    [2];
  logic       we_b    [2];
  logic       sel_a   [2];
  logic       sel_b   [2];
  logic [7:0] wdata_a [2];
  logic [7:0] wdata_b [2];
  logic       ack_a   [2];
  logic       ack_b   [2];
  logic [7:0] rdata   [2];
  logic       busy    [2];
  logic       reg1_cs_b [2];
  logic       reg2_cs_b [2];
  logic       write_strobe_b [2];
  logic       read_strobe_b  [2];
  logic [7:0] bus_dout [2];
  logic       bus_oe   [2];
  logic [7:0] bus_din  [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rdata_m [2];

  always #5 clk = ~clk;

  zube_bus_sequencer dut0 (
    .clk(clk), .reset(reset[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .we_a(we_a[0]), .we_b(we_b[0]),
    .sel_a(sel_a[0]), .sel_b(sel_b[0]), .wdata_a(wdata_a[0]), .wdata_b(wdata_b[0]),
    .ack_a(ack_a[0]), .ack_b(ack_b[0]), .rdata(rdata[0]), .busy(busy[0]),
    .reg1_cs_b(reg1_cs_b[0]), .reg2_cs_b(reg2_cs_b[0]),
    .write_strobe_b(write_strobe_b[0]), .read_strobe_b(read_strobe_b[0]),
    .bus_dout(bus_dout[0]), .bus_oe(bus_oe[0]), .bus_din(bus_din[0])
  );

  zube_bus_sequencer #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .we_a(we_a[1]), .we_b(we_b[1]),
    .sel_a(sel_a[1]), .sel_b(sel_b[1]), .wdata_a(wdata_a[1]), .wdata_b(wdata_b[1]),
    .ack_a(ack_a[1]), .ack_b(ack_b[1]), .rdata(rdata[1]), .busy(busy[1]),
    .reg1_cs_b(reg1_cs_b[1]), .reg2_cs_b(reg2_cs_b[1]),
    .write_strobe_b(write_strobe_b[1]), .read_strobe_b(read_strobe_b[1]),
    .bus_dout(bus_dout[1]), .bus_oe(bus_oe[1]), .bus_din(bus_din[1])
  );

  // {reg1_cs_b, reg2_cs_b, write_strobe_b, read_strobe_b, bus_oe, busy, ack_a, ack_b}
  function automatic logic [7:0] obs_vec(input int d);
    return {reg1_cs_b[d], reg2_cs_b[d], write_strobe_b[d], read_strobe_b[d],
            bus_oe[d], busy[d], ack_a[d], ack_b[d]};
  endfunction

  // Bus invariants watched continuously on both instances.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset[d] === 1'b0) begin
        n_checks++;
        if ((reg1_cs_b[d] === 1'b0 && reg2_cs_b[d] === 1'b0) ||
            (write_strobe_b[d] === 1'b0 && read_strobe_b[d] === 1'b0) ||
            (bus_oe[d] === 1'b1 && read_strobe_b[d] === 1'b0)) begin
          n_fail++;
          $display("FAIL invariant dut%0d: got vec=%b (cs/strobe exclusive, no oe on read required)",
                   d, obs_vec(d));
        end
      end
    end
  end

  // Runs one transfer on instance d; call just after a negedge in an IDLE cycle.
  task automatic do_xfer(input int d, input int s, input int t, input int h,
                         input bit is_b, input bit we, input bit sel,
                         input logic [7:0] wd, input logic [7:0] din);
    int lat;
    logic [7:0] exp_v;
    logic [7:0] exp_rd;
    lat = s + t + h;
    if (is_b) begin
      req_b[d] = 1'b1; we_b[d] = we; sel_b[d] = sel; wdata_b[d] = wd;
    end else begin
      req_a[d] = 1'b1; we_a[d] = we; sel_a[d] = sel; wdata_a[d] = wd;
    end
    bus_din[d] = ~din;
    exp_rd = we ? rdata_m[d] : din;
    for (int k = 0; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (k == s + 2) bus_din[d] = din;
      @(negedge clk);
      exp_v = {!(k < lat && !sel), !(k < lat && sel),
               !(we && k >= s && k < s + t), !(!we && k >= s && k < s + t),
               (we && k < lat), 1'b1, (k == lat && !is_b), (k == lat && is_b)};
      n_checks++;
      if (obs_vec(d) !== exp_v) begin
        n_fail++;
        $display("FAIL xfer_vec dut%0d cycle %0d: got %b, expected %b", d, k, obs_vec(d), exp_v);
      end
      if (we && k < lat) begin
        n_checks++;
        if (bus_dout[d] !== wd) begin
          n_fail++;
          $display("FAIL bus_dout dut%0d cycle %0d: got %h, expected %h", d, k, bus_dout[d], wd);
        end
      end
      if (k == lat) begin
        n_checks++;
        if (rdata[d] !== exp_rd) begin
          n_fail++;
          $display("FAIL rdata dut%0d: got %h, expected %h", d, rdata[d], exp_rd);
        end
      end
    end
    rdata_m[d] = exp_rd;
    req_a[d] = 1'b0;
    req_b[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs_vec(d) !== 8'hF0) begin
      n_fail++;
      $display("FAIL idle_after_ack dut%0d: got %b, expected %b", d, obs_vec(d), 8'hF0);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req_a[d] = 1'b0; req_b[d] = 1'b0;
      we_a[d] = 1'b0; we_b[d] = 1'b0; sel_a[d] = 1'b0; sel_b[d] = 1'b0;
      wdata_a[d] = 8'h00; wdata_b[d] = 8'h00; bus_din[d] = 8'h00;
      rdata_m[d] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_vec(d) !== 8'hF0 || bus_dout[d] !== 8'h00 || rdata[d] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset dut%0d: got vec=%b dout=%h rdata=%h, expected vec=11110000 dout=00 rdata=00",
                 d, obs_vec(d), bus_dout[d], rdata[d]);
      end
      reset[d] = 1'b0;
    end
  endtask

  task automatic test_write_a();
    do_xfer(0, 1, 4, 1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'($urandom));
  endtask

  task automatic test_read_b();
    do_xfer(0, 1, 4, 1, 1'b1, 1'b0, 1'b1, 8'($urandom), 8'h3C);
  endtask

  task automatic test_back_to_back();
    do_xfer(0, 1, 4, 1, 1'b0, 1'b1, 1'b1, 8'h5A, 8'($urandom));
    do_xfer(0, 1, 4, 1, 1'b0, 1'b0, 1'b1, 8'($urandom), 8'h5A);
  endtask

  task automatic test_tie();
    bit pend_a, pend_b, last_b, win_b;
    int cyc, last_ack, acks;
    reset[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset[0] = 1'b0;
    rdata_m[0] = 8'h00;
    req_a[0] = 1'b1; we_a[0] = 1'b1; sel_a[0] = 1'b0; wdata_a[0] = 8'h11;
    req_b[0] = 1'b1; we_b[0] = 1'b1; sel_b[0] = 1'b1; wdata_b[0] = 8'h22;
    pend_a = 1'b1; pend_b = 1'b1; last_b = 1'b1;
    cyc = 0; last_ack = 0; acks = 0;
    while (acks < 4 && cyc < 200) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (ack_a[0] === 1'b1 || ack_b[0] === 1'b1) begin
        if (pend_a && pend_b) win_b = RR ? !last_b : 1'b0;
        else                  win_b = pend_b;
        last_b = win_b;
        n_checks++;
        if ({ack_a[0], ack_b[0]} !== {!win_b, win_b}) begin
          n_fail++;
          $display("FAIL tie_grant #%0d: got ack_a=%b ack_b=%b, expected ack_a=%b ack_b=%b",
                   acks, ack_a[0], ack_b[0], !win_b, win_b);
        end
        n_checks++;
        if ((cyc - last_ack) !== ((acks == 0) ? 7 : 8)) begin
          n_fail++;
          $display("FAIL tie_spacing #%0d: got %0d cycles, expected %0d",
                   acks, cyc - last_ack, (acks == 0) ? 7 : 8);
        end
        last_ack = cyc;
        if (acks == 2) begin pend_a = 1'b0; req_a[0] = 1'b0; end
        if (acks == 3) begin pend_b = 1'b0; req_b[0] = 1'b0; end
        acks++;
      end
    end
    n_checks++;
    if (acks != 4) begin
      n_fail++;
      $display("FAIL tie_timeout: got %0d acks, expected 4", acks);
    end
    req_a[0] = 1'b0;
    req_b[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    req_a[0] = 1'b1; we_a[0] = 1'b1; sel_a[0] = 1'b1; wdata_a[0] = 8'hC3;
    for (int k = 0; k <= 2; k++) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (write_strobe_b[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_in_strobe: got write_strobe_b=%b, expected 0", write_strobe_b[0]);
    end
    reset[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs_vec(0) !== 8'hF0 || bus_dout[0] !== 8'h00 || rdata[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: got vec=%b dout=%h rdata=%h, expected vec=11110000 dout=00 rdata=00",
               obs_vec(0), bus_dout[0], rdata[0]);
    end
    reset[0] = 1'b0;
    req_a[0] = 1'b0;
    rdata_m[0] = 8'h00;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_a[0] !== 1'b0 || ack_b[0] !== 1'b0 || busy[0] !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_no_ack: got %0d active cycles, expected 0", seen);
    end
    do_xfer(0, 1, 4, 1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h96);
  endtask

  task automatic test_random(input int d, input int s, input int t, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      do_xfer(d, s, t, h, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_a();
    test_read_b();
    test_back_to_back();
    test_tie();
    test_reset_mid();
    test_random(0, 1, 4, 1, 20);
    test_random(1, 2, 3, 2, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zube_bus_sequencer.md
# zube_bus_sequencer

- Sequences and arbitrates the shared 8-bit register bus (two chip selects, write/read strobes, bidirectional data) between two on-chip requesters.
- Each requester issues single-register read/write requests over a req/ack handshake; the block generates chip-select and strobe waveforms with programmable setup/strobe/hold cycle counts.
- On reads, it captures the data returned by the selected register peripheral.
- Sits between the on-chip masters and the external register bus pads.

## Interface
Parameters:
- SETUP_CYCLES, 1: cycles chip select (and write data) is asserted before the strobe falls; must be ≥1.
- STROBE_CYCLES, 4: cycles the strobe is held low; must be ≥3, covering the peripheral's 2-cycle sync-plus-register read path.
- HOLD_CYCLES, 1: cycles chip select and write data remain after the strobe rises; must be ≥1.

Ports:
- clk  input  1  sole clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_a, req_b  input  1  transfer request from requester A / B.
- we_a, we_b  input  1  1 = write, 0 = read.
- sel_a, sel_b  input  1  0 = register 1, 1 = register 2.
- wdata_a, wdata_b  input  8  write data.
- ack_a, ack_b  output  1  one-cycle completion pulse.
- rdata  output  8  read data, valid while the corresponding ack is high.
- busy  output  1  high whenever state ≠ IDLE.
- reg1_cs_b, reg2_cs_b  output  1  active-low chip selects.
- write_strobe_b, read_strobe_b  output  1  active-low strobes.
- bus_dout  output  8  data to drive onto the bus.
- bus_oe  output  1  pad output enable for bus_dout.
- bus_din  input  8  data from the bus, already synchronised at the pad.

## Operation
- States: IDLE → SETUP → STROBE → HOLD → ACK → IDLE.
- All bus outputs are registered.
- IDLE: req_a/req_b are sampled only here. On any request:
  - latch the winner's we, sel and wdata;
  - record the winner in last_grant;
  - go to SETUP.
- SETUP: the selected cs_b is low. If write: bus_oe = 1 and bus_dout = latched wdata. Strobes stay high.
- STROBE: the appropriate strobe is low.
  - On read, bus_din is captured into rdata at the final STROBE cycle.
  - On write, rdata is unchanged.
- HOLD: strobes high; cs_b and bus_oe/bus_dout unchanged from STROBE.
- ACK: both cs_b high, bus_oe = 0; ack of the granted requester is high for exactly one cycle.
- A single down-counter times the SETUP, STROBE and HOLD states. It is loaded with the count minus 1 on entry and advances the state at zero.
- Requester rules:
  - hold req, we, sel and wdata stable from assertion until ack;
  - deassert req by the edge ending the ack cycle unless another transfer is wanted;
  - req still high in IDLE after ack starts a new transfer.
- Invariants:
  - reg1_cs_b and reg2_cs_b are never low together;
  - read_strobe_b and write_strobe_b are never low together;
  - bus_oe is never high on a read.
- Simultaneous req_a and req_b in IDLE are resolved per Configuration; the loser remains pending and is served next.
- Reset values: all cs_b and strobes = 1; bus_oe = 0; bus_dout = 0x00; rdata = 0x00; ack_a = ack_b = 0; busy = 0; state IDLE; last_grant = B, so A wins the first tie.
- Reset mid-transfer: on the next edge all outputs take their reset values, no ack is issued, and the transfer is dropped.

## Timing
- Latency from the edge that samples req in IDLE (edge 0) is SETUP+STROBE+HOLD edges; the ack cycle follows the last of those edges. With defaults, ack is high between edges 6 and 7.
- The strobe falls SETUP_CYCLES edges after cs_b falls.
- The read sample edge is the (SETUP+STROBE)th edge.
- Minimum spacing between transfers is one IDLE cycle after ACK, so the total period is SETUP+STROBE+HOLD+2 cycles (8 with defaults).

## Configuration
- ZUBE_BUS_ROUND_ROBIN_EN defined: ties go to the requester not named in last_grant (alternating).
- Undefined: fixed priority; A always wins ties. last_grant is still maintained but unused.

## Test plan
- Write A: req_a, we_a = 1, sel_a = 0, wdata_a = 0xA5 → reg1_cs_b low edges 0–6, write_strobe_b low for 4 cycles starting 1 cycle after cs, bus_oe = 1 with 0xA5 throughout, ack_a single pulse in cycle 7, ack_b never.
- Read B: req_b, we_b = 0, sel_b = 1, bus_din = 0x3C from the strobe's third cycle → read_strobe_b low 4 cycles, bus_oe = 0 throughout, rdata = 0x3C with ack_b.
- Tie: req_a and req_b held high continuously → grants A, B, A, B with the macro; A, A, A without it (B starved). Acks spaced 8 cycles.
- Back-to-back A write then A read of reg2, 0x5A → one IDLE cycle between; rdata = 0x5A.
- Reset asserted during STROBE of a write → next edge strobes/cs high, bus_oe 0, busy 0, no ack; the following transfer completes normally.
- Parameters SETUP = 2, STROBE = 3, HOLD = 2 → strobe low exactly 3 cycles, ack in cycle 8, cs/strobe exclusivity assertions hold throughout.
